// File: rtl/resp_data_checker_pkg.sv
// resp_data_checker_pkg
//   Shared types and constants for the read-response checker:
//   request type, expected-data mode codes, FSM states, summary markers,
//   record/summary field offsets and a saturating increment helper.
package resp_data_checker_pkg;

    typedef enum logic [1:0] {
        REQ_WR  = 2'd0,
        REQ_RD  = 2'd1,
        REQ_RMW = 2'd2,
        REQ_NOP = 2'd3
    } req_t;

    typedef enum logic [5:0] {
        DT_ZERO     = 6'd0,
        DT_ONES     = 6'd1,
        DT_HALF     = 6'd2,
        DT_HALFWORD = 6'd3,
        DT_CHECKER  = 6'd4,
        DT_ADDR     = 6'd5,
        DT_USER     = 6'd6
    } dt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SUMMARY,
        ST_DONE
    } state_e;

    localparam logic [31:0] SUM_MARK     = 32'hFFFF_FFFF;
    localparam logic [31:0] SUM_TO_WORD  = 32'hF0F0_F0F0;
    localparam logic [31:0] HALFWORD_PAT = 32'h0000_FFFF;
    localparam logic [31:0] CHECKER_PAT  = 32'hAAAA_5555;

    // Record header offsets, relative to bit DATA_W of the record.
    localparam int unsigned REC_COL_OFF = 0;
    localparam int unsigned REC_ROW_OFF = 8;
    localparam int unsigned REC_BK_OFF  = 24;
    localparam int unsigned REC_MIS_OFF = 31;

    // Summary word offsets within the low 192 bits.
    localparam int unsigned SUM_GEN_OFF     = 0;
    localparam int unsigned SUM_GEN_RD_OFF  = 32;
    localparam int unsigned SUM_RESP_OFF    = 64;
    localparam int unsigned SUM_RESP_RD_OFF = 96;
    localparam int unsigned SUM_ERR_OFF     = 128;
    localparam int unsigned SUM_TO_OFF      = 160;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/resp_data_checker_if.sv
// resp_data_checker_if
//   Request/response bus seen by the checker.
//   gen_valid/gen_type   : request issued
//   resp_valid/resp_type : response beat and its type
//   resp_bk/row/col      : response address
//   resp_data            : returned data
//   resp_inv             : invert expected data for this beat
//   master drives the bus, slave (the checker) observes it.
interface resp_data_checker_if
    import resp_data_checker_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned BK_W   = 4,
    parameter int unsigned ROW_W  = 14,
    parameter int unsigned COL_W  = 6
) ();
    logic              gen_valid;
    req_t              gen_type;
    logic              resp_valid;
    req_t              resp_type;
    logic [BK_W-1:0]   resp_bk;
    logic [ROW_W-1:0]  resp_row;
    logic [COL_W-1:0]  resp_col;
    logic [DATA_W-1:0] resp_data;
    logic              resp_inv;

    modport master (
        output gen_valid, gen_type, resp_valid, resp_type,
               resp_bk, resp_row, resp_col, resp_data, resp_inv
    );

    modport slave (
        input  gen_valid, gen_type, resp_valid, resp_type,
               resp_bk, resp_row, resp_col, resp_data, resp_inv
    );
endinterface

// File: rtl/resp_data_checker_exp_gen.sv
// dc_exp_gen
//   Combinational expected-data generator.
//   mode_i    : data-type code (unknown codes give zeros)
//   pattern_i : user word replicated in user mode
//   bk_i/row_i/col_i : response address for the address-derived mode
//   inv_i     : invert the result
//   exp_o     : expected data
module dc_exp_gen
    import resp_data_checker_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned BK_W   = 4,
    parameter int unsigned ROW_W  = 14,
    parameter int unsigned COL_W  = 6
) (
    input  logic [5:0]        mode_i,
    input  logic [31:0]       pattern_i,
    input  logic [BK_W-1:0]   bk_i,
    input  logic [ROW_W-1:0]  row_i,
    input  logic [COL_W-1:0]  col_i,
    input  logic              inv_i,
    output logic [DATA_W-1:0] exp_o
);
    logic [31:0]       addr_word;
    logic [DATA_W-1:0] base;

    always_comb begin
        // {bk, 2'b0, row, 2'b0, col}, zero-extended
        addr_word = '0;
        addr_word[COL_W-1:0]               = col_i;
        addr_word[COL_W+2 +: ROW_W]        = row_i;
        addr_word[COL_W+ROW_W+4 +: BK_W]   = bk_i;

        base = '0;
        case (mode_i)
            DT_ZERO:     base = '0;
            DT_ONES:     base = '1;
            DT_HALF:     base[DATA_W/2-1:0] = '1;
            DT_HALFWORD: base = {(DATA_W/32){HALFWORD_PAT}};
            DT_CHECKER:  base = {(DATA_W/32){CHECKER_PAT}};
            DT_ADDR:     base[31:0] = addr_word;
            DT_USER:     base = {(DATA_W/32){pattern_i}};
            default:     base = '0;
        endcase

        exp_o = inv_i ? ~base : base;
    end
endmodule

// File: rtl/resp_data_checker.sv
// resp_data_checker
//   Read-response checker: generates expected data for every READ
//   response, compares it with the returned data, logs records into a
//   capture RAM and writes a summary record at end of test.
//   Optional watchdog: define RESP_DC_TIMEOUT_EN.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, stop       : test start pulse, forced end of test
//   cfg_*             : data mode, user pattern, read count, filter, summary
//   bus               : request/response bus (slave modport)
//   log_we/addr/din   : capture RAM write port
//   busy, done, pass  : test status
//   log_ovf, err_cnt  : log overflow flag, mismatch count
// Record: {mismatch, 3'b0, bk[3:0], row[15:0], col[7:0], data}.
module resp_data_checker
    import resp_data_checker_pkg::*;
#(
    parameter int unsigned DATA_W      = 256,
    parameter int unsigned LOG_AW      = 12,
    parameter int unsigned BK_W        = 4,
    parameter int unsigned ROW_W       = 14,
    parameter int unsigned COL_W       = 6,
    parameter int unsigned TIMEOUT_CYC = 32768
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [5:0]          cfg_data_type,
    input  logic [31:0]         cfg_pattern,
    input  logic [31:0]         cfg_expect_rd,
    input  logic                cfg_err_only,
    input  logic                cfg_summary,
    resp_data_checker_if.slave  bus,
    output logic                log_we,
    output logic [LOG_AW-1:0]   log_addr,
    output logic [DATA_W+31:0]  log_din,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                log_ovf,
    output logic [31:0]         err_cnt
);
    state_e              state_q;
    logic                busy_q, done_q, pass_q, log_we_q, log_ovf_q, full_q;
    logic [LOG_AW-1:0]   log_addr_q, ptr_q;
    logic [DATA_W+31:0]  log_din_q;
    logic [31:0]         gen_q, gen_rd_q, resp_q, resp_rd_q, err_q;

    logic                s1_vld_q;
    logic [BK_W-1:0]     s1_bk_q;
    logic [ROW_W-1:0]    s1_row_q;
    logic [COL_W-1:0]    s1_col_q;
    logic [DATA_W-1:0]   s1_data_q, s1_exp_q;

    logic [DATA_W-1:0]   exp_d;
    logic                run, end_now, accept, acc_rd, mismatch, rec_keep;
    logic                timeout_hit, timeout_flag;
    logic [DATA_W+31:0]  rec_d, sum_d;

    dc_exp_gen #(
        .DATA_W (DATA_W),
        .BK_W   (BK_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_exp_gen (
        .mode_i    (cfg_data_type),
        .pattern_i (cfg_pattern),
        .bk_i      (bus.resp_bk),
        .row_i     (bus.resp_row),
        .col_i     (bus.resp_col),
        .inv_i     (bus.resp_inv),
        .exp_o     (exp_d)
    );

`ifdef RESP_DC_TIMEOUT_EN
    logic [31:0] idle_q;
    logic        timeout_q;

    assign timeout_hit  = (state_q == ST_RUN) && (idle_q >= 32'(TIMEOUT_CYC));
    assign timeout_flag = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_RUN) begin
            idle_q <= (bus.resp_valid || bus.gen_valid) ? '0 : idle_q + 32'd1;
            if (timeout_hit) timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        run     = (state_q == ST_RUN);
        end_now = run && (stop || timeout_hit ||
                  (cfg_expect_rd != '0 && resp_rd_q >= cfg_expect_rd));
        // Beats arriving on the ending cycle are not taken, so the pipeline
        // is empty by the time the summary record is written.
        accept  = run && !end_now && bus.resp_valid;
        acc_rd  = accept && (bus.resp_type == REQ_RD);

        mismatch = (s1_data_q != s1_exp_q);
        rec_keep = s1_vld_q && (!cfg_err_only || mismatch);

        rec_d = '0;
        rec_d[DATA_W-1:0]                   = s1_data_q;
        rec_d[DATA_W + REC_COL_OFF +: COL_W] = s1_col_q;
        rec_d[DATA_W + REC_ROW_OFF +: ROW_W] = s1_row_q;
        rec_d[DATA_W + REC_BK_OFF  +: BK_W]  = s1_bk_q;
        rec_d[DATA_W + REC_MIS_OFF]          = mismatch;

        sum_d = '0;
        sum_d[DATA_W+31 -: 32]          = SUM_MARK;
        sum_d[SUM_GEN_OFF     +: 32]    = gen_q;
        sum_d[SUM_GEN_RD_OFF  +: 32]    = gen_rd_q;
        sum_d[SUM_RESP_OFF    +: 32]    = resp_q;
        sum_d[SUM_RESP_RD_OFF +: 32]    = resp_rd_q;
        sum_d[SUM_ERR_OFF     +: 32]    = err_q;
        sum_d[SUM_TO_OFF      +: 32]    = timeout_flag ? SUM_TO_WORD : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            log_we_q   <= 1'b0;
            log_addr_q <= '0;
            log_din_q  <= '0;
            log_ovf_q  <= 1'b0;
            full_q     <= 1'b0;
            ptr_q      <= '0;
            gen_q      <= '0;
            gen_rd_q   <= '0;
            resp_q     <= '0;
            resp_rd_q  <= '0;
            err_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_bk_q    <= '0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s1_data_q  <= '0;
            s1_exp_q   <= '0;
        end else begin
            log_we_q <= 1'b0;
            done_q   <= 1'b0;

            // Stage 1: register the read beat and its expected data.
            s1_vld_q  <= acc_rd;
            s1_bk_q   <= bus.resp_bk;
            s1_row_q  <= bus.resp_row;
            s1_col_q  <= bus.resp_col;
            s1_data_q <= bus.resp_data;
            s1_exp_q  <= exp_d;

            // Stage 2: compare and log.
            if (s1_vld_q && mismatch) err_q <= sat_inc(err_q);
            if (rec_keep) begin
                if (full_q) begin
                    log_ovf_q <= 1'b1;
                end else begin
                    log_we_q   <= 1'b1;
                    log_addr_q <= ptr_q;
                    log_din_q  <= rec_d;
                    if (ptr_q == '1) full_q <= 1'b1;
                    else             ptr_q  <= ptr_q + 1'b1;
                end
            end

            if (run) begin
                if (bus.gen_valid)                          gen_q    <= sat_inc(gen_q);
                if (bus.gen_valid && bus.gen_type == REQ_RD) gen_rd_q <= sat_inc(gen_rd_q);
                if (accept)                                 resp_q   <= sat_inc(resp_q);
                if (acc_rd)                                 resp_rd_q <= sat_inc(resp_rd_q);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        log_ovf_q <= 1'b0;
                        full_q    <= 1'b0;
                        gen_q     <= '0;
                        gen_rd_q  <= '0;
                        resp_q    <= '0;
                        resp_rd_q <= '0;
                        err_q     <= '0;
                        if (cfg_summary) begin
                            log_we_q   <= 1'b1;
                            log_addr_q <= '0;
                            log_din_q  <= '0;
                            ptr_q      <= LOG_AW'(1);
                        end else begin
                            ptr_q      <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (end_now) state_q <= ST_SUMMARY;
                end
                ST_SUMMARY: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0) && !timeout_flag;
                    if (cfg_summary) begin
                        log_we_q   <= 1'b1;
                        log_addr_q <= '0;
                        log_din_q  <= sum_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign log_we   = log_we_q;
    assign log_addr = log_addr_q;
    assign log_din  = log_din_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign log_ovf  = log_ovf_q;
    assign err_cnt  = err_q;
endmodule

// File: tb/tb_resp_data_checker.sv
// tb_resp_data_checker
//   Directed bench for resp_data_checker. Instance A uses the default
//   log depth; instance B uses an 8-entry log and a 16-cycle watchdog.
//   Both observe the same bus; only the started instance reacts.
module tb_resp_data_checker;
    import resp_data_checker_pkg::*;

    localparam int unsigned DW = 256;
    localparam int unsigned LW = DW + 32;

    typedef struct {
        int unsigned    addr;
        logic [LW-1:0]  din;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, stop;
    logic [5:0]  cfg_data_type;
    logic [31:0] cfg_pattern, cfg_expect_rd;
    logic        cfg_err_only, cfg_summary;

    logic          we_a, busy_a, done_a, pass_a, ovf_a;
    logic [11:0]   addr_a;
    logic [LW-1:0] din_a;
    logic [31:0]   err_a;
    logic          we_b, busy_b, done_b, pass_b, ovf_b;
    logic [2:0]    addr_b;
    logic [LW-1:0] din_b;
    logic [31:0]   err_b;

    resp_data_checker_if #(.DATA_W(DW), .BK_W(4), .ROW_W(14), .COL_W(6)) bus ();

    resp_data_checker #(
        .DATA_W(DW), .LOG_AW(12), .BK_W(4), .ROW_W(14), .COL_W(6), .TIMEOUT_CYC(32768)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop),
        .cfg_data_type(cfg_data_type), .cfg_pattern(cfg_pattern),
        .cfg_expect_rd(cfg_expect_rd), .cfg_err_only(cfg_err_only),
        .cfg_summary(cfg_summary), .bus(bus),
        .log_we(we_a), .log_addr(addr_a), .log_din(din_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .log_ovf(ovf_a), .err_cnt(err_a)
    );

    resp_data_checker #(
        .DATA_W(DW), .LOG_AW(3), .BK_W(4), .ROW_W(14), .COL_W(6), .TIMEOUT_CYC(16)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop),
        .cfg_data_type(cfg_data_type), .cfg_pattern(cfg_pattern),
        .cfg_expect_rd(cfg_expect_rd), .cfg_err_only(cfg_err_only),
        .cfg_summary(cfg_summary), .bus(bus),
        .log_we(we_b), .log_addr(addr_b), .log_din(din_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .log_ovf(ovf_b), .err_cnt(err_b)
    );

    rec_t        cap_a[$], cap_b[$];
    int unsigned done_cnt_a = 0, done_cnt_b = 0;
    logic        pass_at_done_a = 1'b0, pass_at_done_b = 1'b0;
    int unsigned last_wait = 0;
    int unsigned n_tests = 0, n_fail = 0;

    always @(negedge clk) begin
        rec_t r;
        if (we_a) begin r.addr = 32'(addr_a); r.din = din_a; cap_a.push_back(r); end
        if (we_b) begin r.addr = 32'(addr_b); r.din = din_b; cap_b.push_back(r); end
        if (done_a) begin done_cnt_a++; pass_at_done_a = pass_a; end
        if (done_b) begin done_cnt_b++; pass_at_done_b = pass_b; end
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk_rec(input logic mis, input logic [3:0] bk,
                                             input logic [15:0] row, input logic [7:0] col,
                                             input logic [DW-1:0] d);
        return {mis, 3'b000, bk, row, col, d};
    endfunction

    function automatic logic [LW-1:0] mk_sum(input logic [31:0] g, input logic [31:0] gr,
                                             input logic [31:0] r, input logic [31:0] rr,
                                             input logic [31:0] e, input logic to);
        logic [LW-1:0] v;
        v = '0;
        v[LW-1 -: 32] = 32'hFFFF_FFFF;
        v[191:0] = {(to ? 32'hF0F0_F0F0 : 32'h0), e, rr, r, gr, g};
        return v;
    endfunction

    task automatic chk_cap(input bit use_b, input int unsigned i, input string tag,
                           input int unsigned addr, input logic [LW-1:0] din);
        rec_t r;
        r.addr = 32'hFFFF_FFFF;
        r.din  = 'x;
        if (!use_b && i < cap_a.size()) r = cap_a[i];
        if (use_b && i < cap_b.size())  r = cap_b[i];
        check({tag, "_addr"}, LW'(r.addr), LW'(addr));
        check({tag, "_din"}, r.din, din);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic gv, input req_t typ, input logic rv,
                        input logic [3:0] bk, input logic [13:0] row, input logic [5:0] col,
                        input logic [DW-1:0] d, input logic inv);
        bus.gen_valid  = gv;
        bus.gen_type   = typ;
        bus.resp_valid = rv;
        bus.resp_type  = typ;
        bus.resp_bk    = bk;
        bus.resp_row   = row;
        bus.resp_col   = col;
        bus.resp_data  = d;
        bus.resp_inv   = inv;
        cyc();
        bus.gen_valid  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_inv   = 1'b0;
    endtask

    task automatic pulse_start(input bit use_b);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input string tag);
        int unsigned base;
        int unsigned n;
        base = use_b ? done_cnt_b : done_cnt_a;
        n = 0;
        while ((use_b ? done_cnt_b : done_cnt_a) == base && n < 200) begin
            cyc();
            n++;
        end
        check({tag, "_done"}, LW'((use_b ? done_cnt_b : done_cnt_a) - base), LW'(1));
        last_wait = n;
        cyc();
    endtask

    task automatic set_cfg(input logic [5:0] mode, input logic [31:0] exp_rd,
                           input logic err_only, input logic summary);
        cfg_data_type = mode;
        cfg_expect_rd = exp_rd;
        cfg_err_only  = err_only;
        cfg_summary   = summary;
    endtask

    // Checkerboard mode, three matching reads, summary enabled.
    task automatic run_t1(input string tag);
        logic [DW-1:0] pat;
        pat = {8{32'hAAAA_5555}};
        set_cfg(6'd4, 32'd3, 1'b0, 1'b1);
        cap_a.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++)
            beat(1'b1, REQ_RD, 1'b1, 4'd1, 14'(i), 6'(i), pat, 1'b0);
        wait_done(1'b0, tag);
        check({tag, "_nwr"}, LW'(cap_a.size()), LW'(5));
        chk_cap(1'b0, 0, {tag, "_init"}, 0, '0);
        for (int i = 0; i < 3; i++)
            chk_cap(1'b0, 32'(i + 1), $sformatf("%s_rec%0d", tag, i), 32'(i + 1),
                    mk_rec(1'b0, 4'd1, 16'(i), 8'(i), pat));
        chk_cap(1'b0, 4, {tag, "_sum"}, 0, mk_sum(32'd3, 32'd3, 32'd3, 32'd3, 32'd0, 1'b0));
        check({tag, "_pass"}, LW'(pass_at_done_a), LW'(1));
        check({tag, "_err"}, LW'(err_a), LW'(0));
    endtask

    initial begin
        logic [DW-1:0] good, bad, ones;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; stop = 1'b0;
        cfg_pattern = 32'h1234_5678;
        set_cfg(6'd0, 32'd0, 1'b0, 1'b0);
        bus.gen_valid = 1'b0; bus.gen_type = REQ_NOP; bus.resp_valid = 1'b0;
        bus.resp_type = REQ_NOP; bus.resp_bk = '0; bus.resp_row = '0;
        bus.resp_col = '0; bus.resp_data = '0; bus.resp_inv = 1'b0;
        repeat (3) cyc();
        check("rst_outs", LW'({we_a, addr_a, busy_a, done_a, pass_a, ovf_a, err_a}), '0);
        check("rst_din", din_a, '0);
        rst = 1'b0;
        cyc();

        // T1: checkerboard, three good reads
        run_t1("t1");

        // T2: address mode, inverted, second read corrupted in bit 0, errors only
        set_cfg(6'd5, 32'd2, 1'b1, 1'b1);
        good = {{224{1'b1}}, 32'hFCFE_AAD5};
        bad  = good ^ DW'(1);
        cap_a.delete();
        pulse_start(1'b0);
        beat(1'b0, REQ_RD, 1'b1, 4'd3, 14'h155, 6'h2A, good, 1'b1);
        beat(1'b0, REQ_RD, 1'b1, 4'd3, 14'h155, 6'h2A, bad, 1'b1);
        wait_done(1'b0, "t2");
        check("t2_nwr", LW'(cap_a.size()), LW'(3));
        chk_cap(1'b0, 1, "t2_rec", 1, mk_rec(1'b1, 4'd3, 16'h0155, 8'h2A, bad));
        chk_cap(1'b0, 2, "t2_sum", 0, mk_sum(32'd0, 32'd0, 32'd2, 32'd2, 32'd1, 1'b0));
        check("t2_err", LW'(err_a), LW'(1));
        check("t2_pass", LW'(pass_at_done_a), LW'(0));

        // T3: 8-entry log, no summary slot, 10 reads
        set_cfg(6'd0, 32'd10, 1'b0, 1'b0);
        cap_b.delete();
        pulse_start(1'b1);
        for (int i = 0; i < 10; i++)
            beat(1'b0, REQ_RD, 1'b1, 4'd0, 14'd0, 6'(i), '0, 1'b0);
        wait_done(1'b1, "t3");
        check("t3_nwr", LW'(cap_b.size()), LW'(8));
        for (int i = 0; i < 8; i++)
            chk_cap(1'b1, 32'(i), $sformatf("t3_rec%0d", i), 32'(i),
                    mk_rec(1'b0, 4'd0, 16'd0, 8'(i), '0));
        check("t3_ovf", LW'(ovf_b), LW'(1));
        check("t3_pass", LW'(pass_at_done_b), LW'(1));

        // T3b: same with summary slot; counters still see all 10 reads
        set_cfg(6'd0, 32'd10, 1'b0, 1'b1);
        cap_b.delete();
        pulse_start(1'b1);
        for (int i = 0; i < 10; i++)
            beat(1'b0, REQ_RD, 1'b1, 4'd0, 14'd0, 6'(i), '0, 1'b0);
        wait_done(1'b1, "t3b");
        check("t3b_nwr", LW'(cap_b.size()), LW'(9));
        chk_cap(1'b1, 7, "t3b_last", 7, mk_rec(1'b0, 4'd0, 16'd0, 8'd6, '0));
        chk_cap(1'b1, 8, "t3b_sum", 0, mk_sum(32'd0, 32'd0, 32'd10, 32'd10, 32'd0, 1'b0));
        check("t3b_ovf", LW'(ovf_b), LW'(1));

        // T4: gen+resp together for 5 cycles, third is a WRITE; end by stop
        set_cfg(6'd1, 32'd0, 1'b0, 1'b1);
        ones = '1;
        cap_a.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++)
            beat(1'b1, (i == 2) ? REQ_WR : REQ_RD, 1'b1, 4'd2, 14'd7, 6'(i), ones, 1'b0);
        repeat (3) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        wait_done(1'b0, "t4");
        check("t4_nwr", LW'(cap_a.size()), LW'(6));
        chk_cap(1'b0, 3, "t4_rec3", 3, mk_rec(1'b0, 4'd2, 16'd7, 8'd3, ones));
        chk_cap(1'b0, 5, "t4_sum", 0, mk_sum(32'd5, 32'd4, 32'd5, 32'd4, 32'd0, 1'b0));
        check("t4_pass", LW'(pass_at_done_a), LW'(1));

        // T5: reset while a read is in the pipeline
        set_cfg(6'd0, 32'd0, 1'b0, 1'b1);
        cap_a.delete();
        pulse_start(1'b0);
        beat(1'b0, REQ_RD, 1'b1, 4'd0, 14'd0, 6'd0, '0, 1'b0);
        rst = 1'b1;
        cyc();
        check("t5_outs", LW'({we_a, addr_a, busy_a, done_a, pass_a, ovf_a, err_a}), '0);
        check("t5_din", din_a, '0);
        rst = 1'b0;
        repeat (4) cyc();
        check("t5_nwr", LW'(cap_a.size()), LW'(1));
        check("t5_busy", LW'(busy_a), LW'(0));
        run_t1("t5r");

`ifdef RESP_DC_TIMEOUT_EN
        // T6: watchdog with no traffic
        set_cfg(6'd0, 32'd0, 1'b0, 1'b1);
        cap_b.delete();
        pulse_start(1'b1);
        wait_done(1'b1, "t6");
        check("t6_lat", LW'(last_wait >= 16 && last_wait <= 21), LW'(1));
        check("t6_nwr", LW'(cap_b.size()), LW'(2));
        chk_cap(1'b1, 1, "t6_sum", 0, mk_sum(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1));
        check("t6_pass", LW'(pass_at_done_b), LW'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
